// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift 8 data
// bits + odd parity + stop on device clock falling edges, then check the device ACK.
//
// state    | meaning
// IDLE     | lines released, waiting for tx_start
// INHIBIT  | holding PS/2 clock low for INHIBIT_CYCLES
// REQ      | clock released, data low (start bit), waiting for first device edge
// SHIFT    | driving data bits, parity and stop on each device falling edge
// ACK      | lines released, sampling device ACK on next falling edge
// WAIT_REL | waiting for device to release clock and data
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int INH_W = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_REL
    } state_t;

    state_t state_q, state_d;

    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic fe;

    logic [8:0]       frame_q, frame_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             timed;

    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= ps2_data_in;
            data_s2  <= data_s1;
        end
    end

    assign fe = clk_prev & ~clk_s2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            bit_idx_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        timed     = (state_q == REQ) || (state_q == SHIFT) ||
                    (state_q == ACK) || (state_q == WAIT_REL);

        // Device-edge watchdog: reloaded on every falling edge, else counts down to zero
        if (timed) begin
            if (fe) begin
                to_cnt_d = TO_LOAD;
            end else if (to_cnt_q != '0) begin
                to_cnt_d = to_cnt_q - 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                if (tx_start) begin
                    frame_d   = {~^tx_data, tx_data};
                    bit_idx_d = '0;
                    inh_cnt_d = INH_LOAD;
                    to_cnt_d  = TO_LOAD;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == '0) begin
                    data_oe_d = 1'b1;
                    to_cnt_d  = TO_LOAD;
                    state_d   = REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q - 1'b1;
                end
            end
            REQ: begin
                if (fe) begin
                    data_oe_d = ~frame_q[0];
                    bit_idx_d = 4'd1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // bit_idx 1..8 are data bits 1..7 then parity; 9 is the stop bit
                if (fe) begin
                    if (bit_idx_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        data_oe_d = ~frame_q[bit_idx_q];
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            ACK: begin
                if (fe) begin
                    if (!data_s2) begin
                        state_d = WAIT_REL;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_REL: begin
                if (clk_s2 && data_s2) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        if (timed && !fe && (to_cnt_q == '0)) begin
            data_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
            state_d   = IDLE;
        end
    end

    assign ps2_clk_oe  = (state_q == INHIBIT);
    assign ps2_data_oe = data_oe_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector PS/2 device model with a 40-cycle clock,
// table of command bytes plus timeout and mid-transfer reset sequences.
module tb_ps2_host_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int done_busy_bad = 0;
    logic prev_busy = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(500)) dut (
        .CLK(CLK), .RST(RST), .tx_data(tx_data), .tx_start(tx_start),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .busy(busy), .done(done), .err(err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       poke;
        logic [8:0] exp_frame;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
        if (done && (busy || !prev_busy)) done_busy_bad++;
        prev_busy = busy;
    endtask

    task automatic clear_mon();
        done_cnt = 0;
        err_cnt = 0;
        both_cnt = 0;
        done_busy_bad = 0;
    endtask

    // One device clock period: 20 cycles low, 20 high. Host bit captured mid-low phase.
    task automatic dev_edge(input logic pull_ack, input logic poke,
                            output logic b, output logic stable);
        logic v;
        v = 1'b0;
        stable = 1'b1;
        dev_clk_low = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 6) v = ps2_data_oe;
            else if (i > 6 && ps2_data_oe !== v) stable = 1'b0;
        end
        dev_clk_low = 1'b0;
        dev_data_low = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tx_start = poke && (i == 5);
            if (pull_ack && i == 10) dev_data_low = 1'b1;
            tick();
            if (ps2_data_oe !== v) stable = 1'b0;
        end
        tx_start = 1'b0;
        b = ~v;
    endtask

    task automatic start_and_inhibit(input logic [7:0] d, output int inh_len, output logic start_ok);
        tx_data = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tx_data = ~d;
        inh_len = 0;
        while (ps2_clk_oe && inh_len < 200) begin
            inh_len++;
            tick();
        end
        start_ok = ps2_data_oe && !ps2_clk_oe && busy;
        repeat (5) tick();
    endtask

    task automatic run_xfer(input logic [7:0] d, input logic ack, input logic poke,
                            output logic [8:0] bits, output logic stop_bit,
                            output int inh_len, output logic start_ok, output logic stable_all);
        logic b, st;
        bits = '0;
        stop_bit = 1'b0;
        stable_all = 1'b1;
        start_and_inhibit(d, inh_len, start_ok);
        for (int e = 1; e <= 11; e++) begin
            dev_edge((e == 10) && ack, poke && (e == 4), b, st);
            if (e <= 9) bits[e-1] = b;
            if (e == 10) stop_bit = b;
            stable_all = stable_all && st;
        end
        dev_data_low = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        logic [8:0] bits;
        logic       stop_bit, start_ok, stable_all, idle_ok, b, st;
        int         inh_len, n;

        vecs[0] = '{8'hED, 1'b1, 1'b0, 9'h1ED, 1, 0};
        vecs[1] = '{8'hF4, 1'b1, 1'b1, 9'h0F4, 1, 0};
        vecs[2] = '{8'hFF, 1'b0, 1'b0, 9'h1FF, 0, 1};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 9'h100, 1, 0};
        vecs[4] = '{8'hA5, 1'b1, 1'b0, 9'h1A5, 1, 0};
        vecs[5] = '{8'h01, 1'b1, 1'b0, 9'h001, 1, 0};

        RST = 1'b1;
        repeat (3) tick();
        check("reset_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, busy, done, err}, 32'd0);
        RST = 1'b0;
        repeat (3) tick();
        check("idle_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, busy, done, err}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            clear_mon();
            run_xfer(vecs[v].data, vecs[v].ack, vecs[v].poke, bits, stop_bit,
                     inh_len, start_ok, stable_all);
            idle_ok = 1'b1;
            for (int i = 0; i < 60; i++) begin
                tick();
                if (busy || ps2_clk_oe || ps2_data_oe) idle_ok = 1'b0;
            end
            check($sformatf("inhibit_len[%0d]", v), inh_len, 20);
            check($sformatf("start_bit[%0d]", v), start_ok, 1);
            check($sformatf("frame[%0d]", v), bits, vecs[v].exp_frame);
            check($sformatf("stop_bit[%0d]", v), stop_bit, 1);
            check($sformatf("data_stable[%0d]", v), stable_all, 1);
            check($sformatf("done_count[%0d]", v), done_cnt, vecs[v].exp_done);
            check($sformatf("err_count[%0d]", v), err_cnt, vecs[v].exp_err);
            check($sformatf("done_err_overlap[%0d]", v), both_cnt, 0);
            check($sformatf("busy_on_done[%0d]", v), done_busy_bad, 0);
            check($sformatf("idle_after[%0d]", v), idle_ok, 1);
        end

        // Device stops clocking after 3 edges: watchdog abort
        clear_mon();
        start_and_inhibit(8'h00, inh_len, start_ok);
        check("to_inhibit_len", inh_len, 20);
        for (int e = 1; e <= 2; e++) dev_edge(1'b0, 1'b0, b, st);
        n = 0;
        while (n < 700) begin
            n++;
            dev_clk_low = (n <= 20);
            tick();
            if (err) break;
        end
        checks++;
        if (n < 500 || n > 504) begin
            failures++;
            $display("FAIL timeout_latency: got %0d cycles expected 500..504", n);
        end
        check("timeout_lines", {29'd0, ps2_clk_oe, ps2_data_oe, busy}, 32'd0);
        repeat (5) tick();
        check("timeout_err_count", err_cnt, 1);
        check("timeout_done_count", done_cnt, 0);

        // Reset in the middle of bit 4, then a normal transfer
        clear_mon();
        start_and_inhibit(8'hED, inh_len, start_ok);
        for (int e = 1; e <= 4; e++) dev_edge(1'b0, 1'b0, b, st);
        dev_clk_low = 1'b1;
        repeat (8) tick();
        check("bit4_driven", ps2_data_oe, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_mid_lines", {27'd0, ps2_clk_oe, ps2_data_oe, busy, done, err}, 32'd0);
        dev_clk_low = 1'b0;
        repeat (30) tick();
        check("rst_mid_no_pulse", done_cnt + err_cnt, 0);

        clear_mon();
        run_xfer(8'hED, 1'b1, 1'b0, bits, stop_bit, inh_len, start_ok, stable_all);
        repeat (20) tick();
        check("post_rst_frame", bits, 9'h1ED);
        check("post_rst_done", done_cnt, 1);
        check("post_rst_err", err_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
